// File: rtl/frac_pixel_sched_if.sv
// Engine command/result and pixel-stream bundle for frac_pixel_sched.
// master = scheduler side, slave = engine / frame-buffer side.
interface frac_pixel_sched_if #(
  parameter int N  = 32,
  parameter int XW = 10,
  parameter int YW = 9
) ();
  logic [N-1:0]  eng_cx;
  logic [N-1:0]  eng_cy;
  logic [15:0]   eng_max_iter;
  logic          eng_go;
  logic          eng_busy;
  logic          eng_done_tick;
  logic          eng_found;
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_found;

  modport master (
    output eng_cx, eng_cy, eng_max_iter, eng_go,
    input  eng_busy, eng_done_tick, eng_found,
    output pix_valid, pix_x, pix_y, pix_found,
    input  pix_ready
  );

  modport slave (
    input  eng_cx, eng_cy, eng_max_iter, eng_go,
    output eng_busy, eng_done_tick, eng_found,
    input  pix_valid, pix_x, pix_y, pix_found,
    output pix_ready
  );
endinterface

// File: rtl/frac_pixel_sched.sv
// Raster-order frame scheduler for one escape-time engine.
// Walks the grid by repeated addition and streams one found flag per pixel.
module frac_pixel_sched #(
  parameter int N    = 32,
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int XW   = 10,
  parameter int YW   = 9
) (
  input  logic         frac_clk,
  input  logic         frac_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] cfg_cx0,
  input  logic [N-1:0] cfg_cy0,
  input  logic [N-1:0] cfg_dx,
  input  logic [N-1:0] cfg_dy,
  input  logic [15:0]  cfg_max_iter,
  output logic         busy,
  output logic         frame_done_tick,
  frac_pixel_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE, S_DRAIN
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(HRES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VRES - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, px_q;
  logic [YW-1:0] y_q, py_q;
  logic [N-1:0]  cx_q, cy_q;
  logic [N-1:0]  cx0_q, dx_q, dy_q;
  logic [15:0]   mi_q;
  logic          pf_q;
  logic          row_end, last;

  assign row_end = (x_q == X_LAST);
  assign last    = row_end && (y_q == Y_LAST);

  always_ff @(posedge frac_clk or posedge frac_rst) begin
    if (frac_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_ISSUE;
      S_ISSUE: if (abort) state_d = S_IDLE;
               else if (!bus.eng_busy) state_d = S_WAIT;
      S_WAIT:  if (abort) state_d = S_DRAIN;
               else if (bus.eng_done_tick) state_d = S_EMIT;
      S_EMIT:  if (abort) state_d = S_IDLE;
               else if (bus.pix_ready)
                 state_d = last ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (bus.eng_done_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // abort wins over a same-cycle go so a killed frame never starts the engine
  always_comb begin
    bus.eng_go      = (state_q == S_ISSUE) && !bus.eng_busy && !abort;
    bus.pix_valid   = (state_q == S_EMIT);
    busy            = (state_q != S_IDLE);
    frame_done_tick = (state_q == S_DONE);
  end

  always_ff @(posedge frac_clk or posedge frac_rst) begin
    if (frac_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      cx0_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      mi_q  <= '0;
      px_q  <= '0;
      py_q  <= '0;
      pf_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start && !abort) begin
        cx0_q <= cfg_cx0;
        dx_q  <= cfg_dx;
        dy_q  <= cfg_dy;
        mi_q  <= cfg_max_iter;
        cx_q  <= cfg_cx0;
        cy_q  <= cfg_cy0;
        x_q   <= '0;
        y_q   <= '0;
      end
      if (state_q == S_WAIT && bus.eng_done_tick && !abort) begin
        px_q <= x_q;
        py_q <= y_q;
        pf_q <= bus.eng_found;
      end
      if (state_q == S_EMIT && bus.pix_ready && !abort && !last) begin
        if (row_end) begin
          x_q  <= '0;
          cx_q <= cx0_q;
          y_q  <= y_q + 1'b1;
          cy_q <= cy_q + dy_q;
        end else begin
          x_q  <= x_q + 1'b1;
          cx_q <= cx_q + dx_q;
        end
      end
    end
  end

  assign bus.eng_cx       = cx_q;
  assign bus.eng_cy       = cy_q;
  assign bus.eng_max_iter = mi_q;
  assign bus.pix_x        = px_q;
  assign bus.pix_y        = py_q;
  assign bus.pix_found    = pf_q;

endmodule

// File: tb/tb_frac_pixel_sched.sv
// Bench for frac_pixel_sched on a 4x2 grid with a 5-cycle behavioural engine.
// A pixel-list model checks every go and every pixel beat; directed cases pin it.
module tb_frac_pixel_sched;
  localparam int N = 32, HRES = 4, VRES = 2, XW = 2, YW = 1;
  localparam int NPIX = HRES * VRES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [31:0] cx0 = '0, cy0 = '0, dx = '0, dy = '0;
  logic [15:0] mi = '0;
  logic busy, fdt;

  frac_pixel_sched_if #(.N(N), .XW(XW), .YW(YW)) bus ();

  frac_pixel_sched #(
    .N(N), .HRES(HRES), .VRES(VRES), .XW(XW), .YW(YW)
  ) dut (
    .frac_clk(clk), .frac_rst(rst), .start(start), .abort(abort),
    .cfg_cx0(cx0), .cfg_cy0(cy0), .cfg_dx(dx), .cfg_dy(dy),
    .cfg_max_iter(mi), .busy(busy), .frame_done_tick(fdt), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic fnd(input logic [31:0] x, input logic [31:0] y);
    return x[26] ^ y[27];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // engine: done_tick 5 cycles after go, found derived from the coordinates
  int ecnt = 0;
  logic go_seen = 1'b0;
  logic force_busy = 1'b0;
  logic [31:0] e_cx = '0, e_cy = '0;
  assign bus.eng_busy = force_busy | (ecnt != 0);

  always @(negedge clk) begin
    go_seen = bus.eng_go;
    if (bus.eng_go) begin
      e_cx = bus.eng_cx;
      e_cy = bus.eng_cy;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.eng_done_tick = 1'b0;
    if (rst) ecnt = 0;
    else if (go_seen) ecnt = 4;
    else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) begin
        bus.eng_done_tick = 1'b1;
        bus.eng_found = fnd(e_cx, e_cy);
      end
    end
  end

  // model: list of pixels the current frame must produce, in order
  int n = 0, go_i = 0, pix_i = 0, dones = 0;
  logic [31:0] ex_cx [NPIX];
  logic [31:0] ex_cy [NPIX];
  logic [31:0] got_cx [NPIX];
  logic [31:0] got_cy [NPIX];
  logic [15:0] ex_mi = '0;

  task automatic load(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] da, input logic [31:0] db,
                      input logic [15:0] m);
    n = NPIX; go_i = 0; pix_i = 0; ex_mi = m;
    for (int i = 0; i < NPIX; i++) begin
      ex_cx[i] = a + 32'(i % HRES) * da;
      ex_cy[i] = b + 32'(i / HRES) * db;
      got_cx[i] = '0;
      got_cy[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eng_go) begin
        if (go_i >= n) begin
          checks++; errors++;
          $display("FAIL go_extra got idx=%0d want below %0d", go_i, n);
        end else begin
          chk("go_cx", bus.eng_cx, ex_cx[go_i]);
          chk("go_cy", bus.eng_cy, ex_cy[go_i]);
          chk("go_mi", 32'(bus.eng_max_iter), 32'(ex_mi));
          chk("go_order", go_i, pix_i);
          got_cx[go_i] = bus.eng_cx;
          got_cy[go_i] = bus.eng_cy;
          go_i++;
        end
      end
      if (bus.pix_valid) begin
        if (pix_i >= n || pix_i >= go_i) begin
          checks++; errors++;
          $display("FAIL pix_extra got idx=%0d want below %0d/%0d", pix_i, n, go_i);
        end else begin
          chk("pix_x", 32'(bus.pix_x), pix_i % HRES);
          chk("pix_y", 32'(bus.pix_y), pix_i / HRES);
          chk("pix_found", 32'(bus.pix_found),
              32'(fnd(ex_cx[pix_i], ex_cy[pix_i])));
          if (bus.pix_ready) pix_i++;
        end
      end
      if (fdt) begin
        chk("frame_done_pixels", pix_i, NPIX);
        dones++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] da, input logic [31:0] db,
                             input logic [15:0] m, input bit model);
    cyc();
    cx0 = a; cy0 = b; dx = da; dy = db; mi = m;
    start = 1'b1;
    if (model) load(a, b, da, db, m);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_go(input int k);
    int t = 0;
    while (go_i < k && t < 400) begin cyc(); t++; end
    if (go_i < k) begin
      checks++; errors++;
      $display("FAIL wait_go got=%0d want=%0d", go_i, k);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    int d = dones + 1;
    while (dones < d && t < 1000) begin cyc(); t++; end
    chk("frame_done_seen", dones, d);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_eng_cx"}, bus.eng_cx, 0);
    chk({tag, "_eng_cy"}, bus.eng_cy, 0);
    chk({tag, "_eng_mi"}, 32'(bus.eng_max_iter), 0);
    chk({tag, "_eng_go"}, 32'(bus.eng_go), 0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, "_pix_x"}, 32'(bus.pix_x), 0);
    chk({tag, "_pix_y"}, 32'(bus.pix_y), 0);
    chk({tag, "_pix_found"}, 32'(bus.pix_found), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fdt"}, 32'(fdt), 0);
  endtask

  initial begin
    int d0;
    int t;
    bus.pix_ready = 1'b1;
    repeat (3) cyc();
    zero_chk("reset");
    rst = 1'b0;
    cyc();

    // 1: plain frame
    pulse_start(32'hE000_0000, 32'hF800_0000, 32'h0400_0000, 32'h0800_0000, 16'd30, 1'b1);
    @(negedge clk);
    chk("start_to_go", 32'(bus.eng_go), 1);
    chk("busy_after_start", 32'(busy), 1);
    wait_done();
    repeat (4) cyc();
    chk("t1_gos", go_i, 8);
    chk("t1_dones", dones, 1);
    chk("t1_cx_3_0", got_cx[3], 32'hEC00_0000);
    chk("t1_cy_row1", got_cy[4], 32'h0000_0000);
    chk("t1_cy_row0", got_cy[0], 32'hF800_0000);
    chk("t1_idle", 32'(busy), 0);

    // 2: backpressure on pixel 2
    pulse_start(32'h1000_0000, 32'h0200_0000, 32'h0400_0000, 32'h0800_0000, 16'd5, 1'b1);
    t = 0;
    while (pix_i < 2 && t < 200) begin cyc(); t++; end
    bus.pix_ready = 1'b0;
    t = 0;
    while (!bus.pix_valid && t < 50) begin cyc(); t++; end
    chk("t2_valid_seen", 32'(bus.pix_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(bus.pix_valid), 1);
      chk("t2_hold_x", 32'(bus.pix_x), 2);
      chk("t2_no_go", 32'(bus.eng_go), 0);
      cyc();
    end
    bus.pix_ready = 1'b1;
    wait_done();

    // 3: engine busy for 6 cycles on entering ISSUE
    pulse_start(32'h0000_0000, 32'h0000_0000, 32'h0400_0000, 32'h0800_0000, 16'd9, 1'b1);
    t = 0;
    while (!(bus.pix_valid && bus.pix_x == 2'd1) && t < 200) begin cyc(); t++; end
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("t3_go_held", 32'(bus.eng_go), 0);
    end
    cyc();
    force_busy = 1'b0;
    @(negedge clk);
    chk("t3_go_release", 32'(bus.eng_go), 1);
    wait_done();

    // 4: abort while waiting on pixel 3
    d0 = dones;
    pulse_start(32'hE000_0000, 32'hF800_0000, 32'h0400_0000, 32'h0800_0000, 16'd30, 1'b1);
    wait_go(4);
    cyc();
    abort = 1'b1;
    n = pix_i;
    cyc();
    abort = 1'b0;
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      chk("t4_busy_drain", 32'(busy), 1);
      t++;
      if (bus.eng_done_tick) break;
    end
    chk("t4_done_in_time", 32'(bus.eng_done_tick), 1);
    @(negedge clk);
    chk("t4_idle", 32'(busy), 0);
    repeat (5) cyc();
    chk("t4_no_frame_done", dones, d0);
    chk("t4_pixels", pix_i, 3);

    // 5: second start mid-frame is ignored
    pulse_start(32'h2000_0000, 32'h1000_0000, 32'h0100_0000, 32'h0300_0000, 16'd12, 1'b1);
    wait_go(3);
    pulse_start(32'h5555_0000, 32'h6666_0000, 32'h0000_1000, 32'h0000_2000, 16'd99, 1'b0);
    wait_done();
    chk("t5_gos", go_i, 8);
    chk("t5_cx_last", got_cx[7], 32'h2300_0000);
    chk("t5_cy_last", got_cy[7], 32'h1300_0000);

    // 6: coordinate wrap, then reset mid-frame
    pulse_start(32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0800_0000, 16'd7, 1'b1);
    wait_done();
    chk("t6_wrap", got_cx[1], 32'h8000_0000);
    pulse_start(32'h1234_5678, 32'h0F00_0000, 32'h0000_0100, 32'h0000_0100, 16'd9, 1'b1);
    t = 0;
    while (!(bus.pix_valid && bus.pix_x == 2'd1) && t < 200) begin cyc(); t++; end
    chk("t6_pre_rst_valid", 32'(bus.pix_valid), 1);
    rst = 1'b1;
    n = 0; go_i = 0; pix_i = 0;
    #1;
    zero_chk("midrst");
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    pulse_start(32'hE000_0000, 32'hF800_0000, 32'h0400_0000, 32'h0800_0000, 16'd30, 1'b1);
    wait_done();
    chk("t6_recover_gos", go_i, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
